// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - two-port owner arbiter for the unified instruction/data memory
// Optional per-port transfer counters are built when IMEM_ARB_STATS_EN is defined.
module imem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_lock,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_lock,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   cpu_xfers,
    output logic [15:0]   ldr_xfers
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_CPU = 2'd1, OWN_LDR = 2'd2} state_e;

    localparam int            BW         = $clog2(MAX_BURST + 1);
    localparam int            WW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT);

    state_e        state_q, state_d, idle_pick, oth_state;
    logic [BW-1:0] burst_q, burst_d;
    logic [WW-1:0] cpu_wait_q, cpu_wait_d, ldr_wait_q, ldr_wait_d;
    logic          cpu_rvalid_q, cpu_rvalid_d, ldr_rvalid_q, ldr_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
    logic          own_req, own_lock, oth_req, oth_starved, release_own;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            cpu_wait_q   <= '0;
            ldr_wait_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            cpu_wait_q   <= cpu_wait_d;
            ldr_wait_q   <= ldr_wait_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // Shared by IDLE and by a releasing owner that re-arbitrates on the same edge
    always_comb begin
        if (cpu_req && ldr_req)
            idle_pick = (ldr_wait_q == WAIT_MAX) ? OWN_LDR : OWN_CPU;
        else if (cpu_req)
            idle_pick = OWN_CPU;
        else if (ldr_req)
            idle_pick = OWN_LDR;
        else
            idle_pick = IDLE;
    end

    always_comb begin
        own_req     = 1'b0;
        own_lock    = 1'b0;
        oth_req     = 1'b0;
        oth_starved = 1'b0;
        oth_state   = IDLE;
        release_own = 1'b0;
        state_d     = state_q;
        burst_d     = burst_q;
        case (state_q)
            OWN_CPU: begin
                own_req     = cpu_req;
                own_lock    = cpu_lock;
                oth_req     = ldr_req;
                oth_starved = (ldr_wait_q == WAIT_MAX);
                oth_state   = OWN_LDR;
            end
            OWN_LDR: begin
                own_req     = ldr_req;
                own_lock    = ldr_lock;
                oth_req     = cpu_req;
                oth_starved = (cpu_wait_q == WAIT_MAX);
                oth_state   = OWN_CPU;
            end
            default: ;
        endcase
        if (state_q == IDLE) begin
            state_d = idle_pick;
            burst_d = '0;
        end else begin
            if (!own_req) begin
                release_own = 1'b1;
            end else begin
                burst_d     = burst_q + BW'(1);
                release_own = !own_lock || (burst_q == BURST_LAST) || oth_starved;
            end
            if (release_own) begin
                burst_d = '0;
                if (oth_req)
                    state_d = oth_state;
                else if (own_req && !own_lock)
                    state_d = idle_pick;
                else
                    state_d = IDLE;
            end
        end
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            OWN_CPU: begin
                cpu_gnt   = cpu_req;
                mem_we    = cpu_req && cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_LDR: begin
                ldr_gnt   = ldr_req;
                mem_we    = ldr_req && ldr_we;
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (cpu_gnt)
            cpu_wait_d = '0;
        else if (cpu_req && (cpu_wait_q != WAIT_MAX))
            cpu_wait_d = cpu_wait_q + WW'(1);
        ldr_wait_d = ldr_wait_q;
        if (ldr_gnt)
            ldr_wait_d = '0;
        else if (ldr_req && (ldr_wait_q != WAIT_MAX))
            ldr_wait_d = ldr_wait_q + WW'(1);
        cpu_rvalid_d = cpu_gnt && !cpu_we;
        ldr_rvalid_d = ldr_gnt && !ldr_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
        ldr_rdata_d  = ldr_rvalid_d ? mem_rdata : ldr_rdata_q;
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] cpu_xfers_q, cpu_xfers_d, ldr_xfers_q, ldr_xfers_d;

    always_comb begin
        cpu_xfers_d = cpu_xfers_q;
        ldr_xfers_d = ldr_xfers_q;
        if (cpu_gnt && (cpu_xfers_q != 16'hFFFF))
            cpu_xfers_d = cpu_xfers_q + 16'd1;
        if (ldr_gnt && (ldr_xfers_q != 16'hFFFF))
            ldr_xfers_d = ldr_xfers_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_xfers_q <= 16'h0000;
            ldr_xfers_q <= 16'h0000;
        end else begin
            cpu_xfers_q <= cpu_xfers_d;
            ldr_xfers_q <= ldr_xfers_d;
        end
    end

    assign cpu_xfers = cpu_xfers_q;
    assign ldr_xfers = ldr_xfers_q;
`else
    assign cpu_xfers = 16'h0000;
    assign ldr_xfers = 16'h0000;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter (honours IMEM_ARB_STATS_EN)
`timescale 1ns/1ps
module tb_imem_port_arbiter;
    localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef IMEM_ARB_STATS_EN
    localparam logic [15:0] EXP_CPU_XFERS = 16'd3;
    localparam logic [15:0] EXP_LDR_XFERS = 16'd5;
`else
    localparam logic [15:0] EXP_CPU_XFERS = 16'd0;
    localparam logic [15:0] EXP_LDR_XFERS = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_lock = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ldr_req = 1'b0, ldr_lock = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_we;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] cpu_xfers, ldr_xfers;
    logic        sb_cpu_gnt, sb_cpu_rvalid, sb_ldr_gnt, sb_ldr_rvalid, sb_mem_we;
    logic [31:0] sb_cpu_rdata, sb_ldr_rdata, sb_mem_addr, sb_mem_wdata;
    logic [15:0] sb_cpu_xfers, sb_ldr_xfers;

    logic [31:0] mem_arr [64];
    logic [31:0] exp_mem [64];
    logic [31:0] cpu_q [$];
    logic [31:0] ldr_q [$];
    int          order_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;

    imem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_xfers(cpu_xfers), .ldr_xfers(ldr_xfers)
    );

    // Long bursts allowed here so only the starvation guard can hand the memory over
    imem_port_arbiter #(.AW(32), .DW(32), .MAX_BURST(64), .STARVE_LIMIT(8)) dut_sb (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(sb_cpu_gnt), .cpu_rvalid(sb_cpu_rvalid), .cpu_rdata(sb_cpu_rdata),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(sb_ldr_gnt), .ldr_rvalid(sb_ldr_rvalid), .ldr_rdata(sb_ldr_rdata),
        .mem_we(sb_mem_we), .mem_addr(sb_mem_addr), .mem_wdata(sb_mem_wdata), .mem_rdata(32'h0),
        .cpu_xfers(sb_cpu_xfers), .ldr_xfers(sb_ldr_xfers)
    );

    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (cpu_gnt && ldr_gnt) $display("FAIL both_gnt: cpu_gnt=%b ldr_gnt=%b want not both", cpu_gnt, ldr_gnt);
            else n_pass++;
            n_checks++;
            if (mem_we && !(cpu_gnt || ldr_gnt)) $display("FAIL we_without_gnt: mem_we=%b gnt=0 want mem_we=0", mem_we);
            else n_pass++;
            if (cpu_rvalid) begin
                n_checks++;
                if (cpu_q.size() == 0) $display("FAIL cpu_rvalid_unexpected: rdata=%h want no rvalid", cpu_rdata);
                else begin
                    logic [31:0] e;
                    e = cpu_q.pop_front();
                    if (cpu_rdata !== e) $display("FAIL cpu_rdata: got %h want %h", cpu_rdata, e);
                    else n_pass++;
                end
            end
            if (ldr_rvalid) begin
                n_checks++;
                if (ldr_q.size() == 0) $display("FAIL ldr_rvalid_unexpected: rdata=%h want no rvalid", ldr_rdata);
                else begin
                    logic [31:0] e;
                    e = ldr_q.pop_front();
                    if (ldr_rdata !== e) $display("FAIL ldr_rdata: got %h want %h", ldr_rdata, e);
                    else n_pass++;
                end
            end
            if (cpu_gnt) order_q.push_back(0);
            if (ldr_gnt) order_q.push_back(1);
        end
    end

    task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic lock, output int waited);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_lock = lock;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cpu_gnt) break;
            waited++;
        end
        n_checks++;
        if (!cpu_gnt) $display("FAIL cpu_gnt_timeout: addr %h gnt=%b after %0d cycles want 1", addr, cpu_gnt, waited);
        else begin
            n_pass++;
            if (we) exp_mem[addr[7:2]] = wdata;
            else cpu_q.push_back(exp_mem[addr[7:2]]);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_lock = 1'b0;
    endtask

    task automatic ldr_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic lock, output int waited);
        ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_lock = lock;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ldr_gnt) break;
            waited++;
        end
        n_checks++;
        if (!ldr_gnt) $display("FAIL ldr_gnt_timeout: addr %h gnt=%b after %0d cycles want 1", addr, ldr_gnt, waited);
        else begin
            n_pass++;
            if (we) exp_mem[addr[7:2]] = wdata;
            else ldr_q.push_back(exp_mem[addr[7:2]]);
        end
        @(posedge clk); #1;
        ldr_req = 1'b0; ldr_lock = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = BASE;
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); else n_pass++;
        n_checks++; if (ldr_gnt !== 1'b0) $display("FAIL rst_ldr_gnt: got %b want 0", ldr_gnt); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_cpu_rvalid: got %b want 0", cpu_rvalid); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); else n_pass++;
        n_checks++; if (ldr_rdata !== 32'h0) $display("FAIL rst_ldr_rdata: got %h want 0", ldr_rdata); else n_pass++;
        n_checks++; if (cpu_xfers !== 16'h0) $display("FAIL rst_cpu_xfers: got %h want 0", cpu_xfers); else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL rst_gnt_early: got %b want 0", cpu_gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL rst_gnt_after_release: got %b want 1", cpu_gnt); else n_pass++;
        if (cpu_gnt) cpu_q.push_back(exp_mem[0]);
        @(posedge clk); #1 cpu_req = 1'b0;
        settle();
    endtask

    task automatic test_cpu_read();
        int w;
        cpu_issue(1'b0, BASE, 32'h0, 1'b0, w);
        n_checks++; if (w != 1) $display("FAIL read_latency: waited %0d want 1", w); else n_pass++;
        @(negedge clk);
        n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL read_gnt_once: got %b want 0", cpu_gnt); else n_pass++;
        n_checks++; if (cpu_rvalid !== 1'b1) $display("FAIL read_rvalid: got %b want 1", cpu_rvalid); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0060_0413) $display("FAIL read_rdata: got %h want 00600413", cpu_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL read_rvalid_pulse: got %b want 0", cpu_rvalid); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0060_0413) $display("FAIL read_rdata_hold: got %h want 00600413", cpu_rdata); else n_pass++;
        settle();
    endtask

    task automatic test_ldr_burst();
        int w [6];
        for (int i = 0; i < 6; i++)
            ldr_issue(1'b1, BASE + 32'(i * 4), 32'hA5A5_0000 + 32'(i), (i < 5), w[i]);
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (w[i] != 0) $display("FAIL burst_back_to_back[%0d]: waited %0d want 0", i, w[i]); else n_pass++;
        end
        settle();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (mem_arr[i] !== 32'hA5A5_0000 + 32'(i)) $display("FAIL burst_mem[%0d]: got %h want %h", i, mem_arr[i], 32'hA5A5_0000 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        order_q.delete();
        fork
            begin
                int w;
                for (int i = 0; i < 3; i++) cpu_issue(1'b0, BASE + 32'((i + 1) * 4), 32'h0, 1'b0, w);
            end
            begin
                int w;
                for (int i = 0; i < 3; i++) ldr_issue(1'b1, BASE + 32'h80 + 32'(i * 4), 32'h5EED_0000 + 32'(i), 1'b0, w);
            end
        join
        settle();
        n_checks++; if (order_q.size() != 6) $display("FAIL contention_count: got %0d want 6", order_q.size()); else n_pass++;
        for (int k = 0; k < 6 && k < order_q.size(); k++) begin
            n_checks++; if (order_q[k] != k % 2) $display("FAIL contention_order[%0d]: got port %0d want %0d", k, order_q[k], k % 2); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 4; i++) begin
            cpu_issue(1'b0, BASE + 32'h80 + 32'(i * 4), 32'h0, 1'b0, w);
            if (i > 0) begin
                n_checks++; if (w != 0) $display("FAIL b2b_wait[%0d]: waited %0d want 0", i, w); else n_pass++;
            end
        end
        settle();
    endtask

    task automatic test_starvation();
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        cpu_req = 1'b1; cpu_lock = 1'b1; cpu_we = 1'b1; cpu_addr = BASE + 32'hF0; cpu_wdata = 32'hCAFE_0001;
        ldr_req = 1'b1; ldr_lock = 1'b0; ldr_we = 1'b1; ldr_addr = BASE + 32'hF4; ldr_wdata = 32'hCAFE_0002;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n++;
            if (sb_ldr_gnt) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen || n > 10) $display("FAIL starve_ldr_gnt: granted=%b after %0d cycles want <=10", seen, n); else n_pass++;
        n_checks++; if (n < 2) $display("FAIL starve_cpu_first: ldr granted after %0d cycles want cpu first", n); else n_pass++;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_lock = 1'b0; ldr_req = 1'b0;
        exp_mem[60] = 32'hCAFE_0001;
        exp_mem[61] = 32'hCAFE_0002;
        settle();
    endtask

    task automatic test_stats();
        int w;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_xfers !== 16'h0) $display("FAIL stats_rst_cpu: got %0d want 0", cpu_xfers); else n_pass++;
        n_checks++; if (ldr_xfers !== 16'h0) $display("FAIL stats_rst_ldr: got %0d want 0", ldr_xfers); else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) cpu_issue(1'b1, BASE + 32'hA0 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, w);
        for (int i = 0; i < 5; i++) ldr_issue(1'b1, BASE + 32'hC0 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, w);
        settle();
        n_checks++; if (cpu_xfers !== EXP_CPU_XFERS) $display("FAIL stats_cpu_xfers: got %0d want %0d", cpu_xfers, EXP_CPU_XFERS); else n_pass++;
        n_checks++; if (ldr_xfers !== EXP_LDR_XFERS) $display("FAIL stats_ldr_xfers: got %0d want %0d", ldr_xfers, EXP_LDR_XFERS); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'hC0DE_0000 | 32'(i);
            exp_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem_arr[0] = 32'h0060_0413;
        exp_mem[0] = 32'h0060_0413;
        test_reset();
        test_cpu_read();
        test_ldr_burst();
        test_contention();
        test_back_to_back();
        test_starvation();
        test_stats();
        n_checks++;
        if (cpu_q.size() != 0 || ldr_q.size() != 0) $display("FAIL rvalid_missing: pending cpu=%0d ldr=%0d want 0", cpu_q.size(), ldr_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
